// File: rtl/alu_seq_n.sv
// ============================================================================
// Module      : alu_seq_n
// Description : Handshaked multi-cycle ALU, WIDTH bits wide.
//               Operand bundle is taken on an in_valid/in_ready handshake.
//               The registered result and flags are held until the consumer
//               takes them on an out_valid/out_ready handshake.
//               Ops: AND, OR, XOR, PASSB, ADD, SUB (one cycle), SHL (one bit
//               per cycle) and MUL (shift-add, WIDTH cycles).
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               in_valid  - operands and op are valid
//               in_ready  - block can accept a new operation (IDLE)
//               a, b      - operands; b[SHW-1:0] is the SHL amount
//               cin       - carry-in for ADD (SUB ignores it)
//               op        - operation select
//               out_valid - result and flags valid (DONE)
//               out_ready - consumer accepts the result
//               result    - registered result
//               cout      - carry / no-borrow / shifted-out / high-half-nonzero
//               zero      - result == 0
//               ovf       - signed overflow for ADD/SUB, 0 otherwise
// Config      : define ALU_SAT_EN to make ADD/SUB unsigned-saturating
//               (cout/ovf keep the raw flags, zero follows the saturated
//               result). Undefined: ADD/SUB wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    // Shift-amount field width, derived from WIDTH.
    localparam int unsigned SHW = $clog2(WIDTH);
    // Counter must hold WIDTH itself for MUL.
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [2:0] c_OP_AND   = 3'b000;
    localparam logic [2:0] c_OP_OR    = 3'b001;
    localparam logic [2:0] c_OP_XOR   = 3'b010;
    localparam logic [2:0] c_OP_PASSB = 3'b011;
    localparam logic [2:0] c_OP_ADD   = 3'b100;
    localparam logic [2:0] c_OP_SUB   = 3'b101;
    localparam logic [2:0] c_OP_SHL   = 3'b110;
    localparam logic [2:0] c_OP_MUL   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;       // SHL shift register / MUL multiplicand
    logic [2*WIDTH-1:0]     acc_q, acc_d;   // MUL {high partial, multiplier}
    logic [2:0]             op_q, op_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   cout_q, cout_d;
    logic                   zero_q, zero_d;
    logic                   ovf_q, ovf_d;

    // Single-cycle arithmetic, evaluated straight from the input operands.
    logic [WIDTH:0]         w_sum_add;
    logic [WIDTH:0]         w_sum_sub;
    logic                   w_ovf_add;
    logic                   w_ovf_sub;
    logic [WIDTH-1:0]       w_res_add;
    logic [WIDTH-1:0]       w_res_sub;
    logic [SHW-1:0]         w_shamt;

    // Multi-cycle step values.
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH-1:0]       w_shl_next;

    logic                   w_finish;

    assign w_sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign w_sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Overflow: operand signs agree but the result sign differs (SUB uses ~b).
    assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1])  && (w_sum_add[WIDTH-1] != a[WIDTH-1]);
    assign w_ovf_sub = (a[WIDTH-1] == ~b[WIDTH-1]) && (w_sum_sub[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_SAT_EN
    // Saturate on unsigned carry-out (ADD) or borrow (SUB, raw carry clear).
    assign w_res_add = w_sum_add[WIDTH] ? {WIDTH{1'b1}} : w_sum_add[WIDTH-1:0];
    assign w_res_sub = w_sum_sub[WIDTH] ? w_sum_sub[WIDTH-1:0] : {WIDTH{1'b0}};
`else
    assign w_res_add = w_sum_add[WIDTH-1:0];
    assign w_res_sub = w_sum_sub[WIDTH-1:0];
`endif

    assign w_shamt = b[SHW-1:0];

    // Shift-add multiply: add the multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    // The extra sum bit keeps the carry so nothing is lost before cout.
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    assign w_shl_next = {a_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        acc_d    = acc_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        w_finish = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    a_d   = a;
                    acc_d = {{WIDTH{1'b0}}, b};
                    case (op)
                        c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_PASSB: begin
                            case (op)
                                c_OP_AND: result_d = a & b;
                                c_OP_OR:  result_d = a | b;
                                c_OP_XOR: result_d = a ^ b;
                                default:  result_d = b;
                            endcase
                            cout_d   = 1'b0;
                            ovf_d    = 1'b0;
                            w_finish = 1'b1;
                        end
                        c_OP_ADD: begin
                            result_d = w_res_add;
                            cout_d   = w_sum_add[WIDTH];
                            ovf_d    = w_ovf_add;
                            w_finish = 1'b1;
                        end
                        c_OP_SUB: begin
                            result_d = w_res_sub;
                            cout_d   = w_sum_sub[WIDTH];
                            ovf_d    = w_ovf_sub;
                            w_finish = 1'b1;
                        end
                        c_OP_SHL: begin
                            if (w_shamt == '0) begin
                                result_d = a;
                                cout_d   = 1'b0;
                                ovf_d    = 1'b0;
                                w_finish = 1'b1;
                            end else begin
                                cnt_d   = CW'(w_shamt);
                                state_d = EXEC;
                            end
                        end
                        default: begin
                            cnt_d   = CW'(WIDTH);
                            state_d = EXEC;
                        end
                    endcase
                end
            end

            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == c_OP_MUL) begin
                    acc_d = w_mul_next;
                end else begin
                    a_d = w_shl_next;
                end
                // Final step: the step value itself becomes the result.
                if (cnt_q == CW'(1)) begin
                    if (op_q == c_OP_MUL) begin
                        result_d = w_mul_next[WIDTH-1:0];
                        cout_d   = |w_mul_next[2*WIDTH-1:WIDTH];
                    end else begin
                        result_d = w_shl_next;
                        cout_d   = a_q[WIDTH-1];
                    end
                    ovf_d    = 1'b0;
                    w_finish = 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_finish) begin
            zero_d  = (result_d == '0);
            state_d = DONE;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_n.sv
// ============================================================================
// Module      : tb_alu_seq_n
// Description : Directed + random self-checking bench for alu_seq_n (WIDTH=8).
//               Expected results come from a behavioural model and are queued
//               when an op is driven, then popped when out_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_n;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       zero;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic [7:0] lat;
    } exp_t;

    exp_t sb_q[$];

    alu_seq_n #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x,
                                   input logic [7:0] y, input logic ci);
        exp_t       e;
        logic [8:0] s9;
        logic [15:0] w;
        logic [2:0] amt;
        e = '0;
        e.lat = 8'd1;
        case (o)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: e.res = x ^ y;
            3'b011: e.res = y;
            3'b100: begin
                s9    = {1'b0, x} + {1'b0, y} + {8'd0, ci};
                e.res = s9[7:0];
                e.c   = s9[8];
                e.v   = (x[7] == y[7]) && (e.res[7] != x[7]);
`ifdef ALU_SAT_EN
                if (e.c) e.res = 8'hFF;
`endif
            end
            3'b101: begin
                e.res = x - y;
                e.c   = !(x < y);
                e.v   = (x[7] != y[7]) && (e.res[7] != x[7]);
`ifdef ALU_SAT_EN
                if (!e.c) e.res = 8'h00;
`endif
            end
            3'b110: begin
                amt   = y[2:0];
                w     = {8'h00, x} << amt;
                e.res = w[7:0];
                e.c   = (amt == 3'd0) ? 1'b0 : w[8];
                e.lat = 8'(amt) + 8'd1;
            end
            default: begin
                w     = x * y;
                e.res = w[7:0];
                e.c   = |w[15:8];
                e.lat = 8'd9;
            end
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    // Drive one op, measure latency from the accept edge, check the popped
    // expectation, optionally hold backpressure, then consume the result.
    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input int hold);
        exp_t e;
        int   lat;
        sb_q.push_back(model(o, x, y, ci));
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y; cin = ci;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~x; b = ~y; cin = ~ci;   // later input changes must be ignored
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        chk("latency", lat, 32'(e.lat));
        chk("result", result, e.res);
        chk("cout", cout, e.c);
        chk("zero", zero, e.z);
        chk("ovf", ovf, e.v);
        chk("done_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'b000; a = 8'h55; b = 8'hAA;
            chk("bp_hold", {result, cout, zero, ovf}, {e.res, e.c, e.z, e.v});
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        if (hold > 0) chk("bp_final", {result, cout, zero, ovf}, {e.res, e.c, e.z, e.v});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consume_out_valid", out_valid, 0);
        chk("consume_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flags", {result, cout, zero, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b100, 8'hF0, 8'h20, 1'b1, 0);   // ADD with carry out
        do_op(3'b101, 8'h05, 8'h05, 1'b0, 0);   // SUB equal -> zero
        do_op(3'b101, 8'h03, 8'h05, 1'b1, 0);   // SUB with borrow
        do_op(3'b101, 8'h80, 8'h01, 1'b0, 0);   // SUB signed overflow
        do_op(3'b100, 8'h7F, 8'h01, 1'b0, 0);   // ADD signed overflow
        do_op(3'b111, 8'h12, 8'h10, 1'b0, 0);   // MUL high half nonzero
        do_op(3'b111, 8'hFF, 8'h00, 1'b0, 0);   // MUL by zero
        do_op(3'b110, 8'h81, 8'h03, 1'b0, 0);   // SHL 3
        do_op(3'b110, 8'h81, 8'h00, 1'b0, 0);   // SHL 0
        do_op(3'b110, 8'h81, 8'h01, 1'b0, 0);   // SHL 1
        do_op(3'b110, 8'hC3, 8'hF7, 1'b0, 0);   // SHL 7, upper b bits ignored
        do_op(3'b000, 8'hF0, 8'h3C, 1'b0, 0);
        do_op(3'b001, 8'hF0, 8'h0C, 1'b0, 0);
        do_op(3'b010, 8'hFF, 8'h0F, 1'b0, 0);
        do_op(3'b011, 8'h12, 8'h00, 1'b1, 0);   // PASSB zero result

        // Backpressure while a different op is offered.
        do_op(3'b111, 8'hFF, 8'hFF, 1'b0, 5);
        do_op(3'b010, 8'hA5, 8'h5A, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        // Reset while a MUL is in progress (count = 4).
        @(negedge clk);
        in_valid = 1'b1; op = 3'b111; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", {result, cout, zero, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        do_op(3'b000, 8'hF0, 8'h3C, 1'b0, 0);

        chk("queue_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
